serial_neg_deser: RTL

- Receive-side partner of the bit-serial two's-complement negator.
- Accepts a serial two's-complement-negated stream, LSB first, and re-applies serial negation (copy bits up to and including the first 1, invert every bit after it).
- Deserialises the restored bits into a W-bit parallel word with a one-cycle valid strobe.
- Sits at the far end of the serial link, feeding parallel consumers and the test/compare logic.

---
 rtl/sneg_pkg.sv | 18 +
 rtl/sneg_bit_core.sv | 29 ++
 rtl/serial_neg_deser.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/sneg_pkg.sv
// Shared types and helpers for the serial negation link.
package sneg_pkg;

  localparam int unsigned SNEG_DEFAULT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    DONE  = 2'd3
  } sneg_state_e;

  // Most negative W-bit word (1 followed by zeros); its negation overflows.
  function automatic logic [31:0] sneg_min_val(input int unsigned w);
    return 32'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/sneg_bit_core.sv
// Serial two's-complement negation cell: pass bits up to and including the
// first 1, invert everything after it. Shared by both ends of the link.
module sneg_bit_core (
  input  logic t_clk,
  input  logic r,
  input  logic clr,
  input  logic en,
  input  logic i,
  output logic y
);

  logic seen_one;

  // clr marks bit 0, so an earlier frame's history must not invert it
  assign y = (seen_one && !clr) ? ~i : i;

  always_ff @(posedge t_clk or posedge r) begin
    if (r) begin
      seen_one <= 1'b0;
    end else if (en) begin
      if (clr) begin
        seen_one <= i;
      end else if (i) begin
        seen_one <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_neg_deser.sv
// Serial negation receiver: restores an LSB-first negated stream and
// deserialises it into a W-bit word. Define SNEG_PARITY_EN for a trailing
// even-parity bit per frame and the par_err output.
module serial_neg_deser
  import sneg_pkg::*;
#(
  parameter int unsigned W = SNEG_DEFAULT_W
) (
  input  logic         t_clk,
  input  logic         r,
  input  logic         i,
  input  logic         bv,
  input  logic         sof,
  output logic [W-1:0] data_out,
  output logic         data_valid,
  output logic         ovf,
  output logic         frame_err,
`ifdef SNEG_PARITY_EN
  output logic         par_err,
`endif
  output logic         busy
);

  localparam int unsigned CW = $clog2(W + 1);
  localparam logic [W-1:0] MIN_VAL = W'(sneg_min_val(W));

  sneg_state_e   state, state_n;
  logic [CW-1:0] count, count_n;
  logic [W-2:0]  sreg, sreg_n;
  logic [W-1:0]  word;
  logic [W-1:0]  data_out_n;
  logic          data_valid_n, ovf_n, frame_err_n, busy_n;
  logic          core_en, y;
`ifdef SNEG_PARITY_EN
  logic [W-1:0]  pend, pend_n;
  logic          par, par_n, par_err_n;
`endif

  // Only bits that belong to a frame advance the negation history
  assign core_en = bv && (sof || (state == SHIFT));

  sneg_bit_core u_core (
    .t_clk (t_clk),
    .r     (r),
    .clr   (sof),
    .en    (core_en),
    .i     (i),
    .y     (y)
  );

  assign word = {y, sreg};

  always_comb begin
    state_n      = state;
    count_n      = count;
    sreg_n       = sreg;
    data_out_n   = data_out;
    ovf_n        = ovf;
    data_valid_n = 1'b0;
    frame_err_n  = 1'b0;
`ifdef SNEG_PARITY_EN
    pend_n       = pend;
    par_n        = par;
    par_err_n    = par_err;
`endif

    if (bv && sof) begin
      // sof always restarts; inside a frame it also aborts the partial one
      frame_err_n = (state == SHIFT) || (state == PAR);
      state_n     = SHIFT;
      count_n     = CW'(1);
      sreg_n      = word[W-1:1];
`ifdef SNEG_PARITY_EN
      par_n       = i;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          state_n = IDLE;
        end
        SHIFT: begin
          if (bv) begin
            sreg_n = word[W-1:1];
`ifdef SNEG_PARITY_EN
            par_n  = par ^ i;
`endif
            if (count == CW'(W - 1)) begin
              count_n = CW'(W);
`ifdef SNEG_PARITY_EN
              state_n = PAR;
              pend_n  = word;
`else
              state_n      = DONE;
              data_out_n   = word;
              ovf_n        = (word == MIN_VAL);
              data_valid_n = 1'b1;
`endif
            end else begin
              count_n = count + CW'(1);
            end
          end
        end
        PAR: begin
`ifdef SNEG_PARITY_EN
          if (bv) begin
            state_n      = DONE;
            data_out_n   = pend;
            ovf_n        = (pend == MIN_VAL);
            par_err_n    = par ^ i;
            data_valid_n = 1'b1;
          end
`else
          state_n = IDLE;
`endif
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end

    busy_n = (state_n == SHIFT) || (state_n == PAR);
  end

  always_ff @(posedge t_clk or posedge r) begin
    if (r) begin
      state      <= IDLE;
      count      <= '0;
      sreg       <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      ovf        <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      sreg       <= sreg_n;
      data_out   <= data_out_n;
      data_valid <= data_valid_n;
      ovf        <= ovf_n;
      frame_err  <= frame_err_n;
      busy       <= busy_n;
    end
  end

`ifdef SNEG_PARITY_EN
  // Parity datapath: raw-bit accumulator and the word held across the PAR bit
  always_ff @(posedge t_clk or posedge r) begin
    if (r) begin
      pend    <= '0;
      par     <= 1'b0;
      par_err <= 1'b0;
    end else begin
      pend    <= pend_n;
      par     <= par_n;
      par_err <= par_err_n;
    end
  end
`endif

endmodule
